// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the coordinate type used by the pixel pipeline.
package vga_pkg;

    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;
    localparam int unsigned VGA_CLK_DIV   = 4;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    typedef logic [9:0] coord_t;

    // True when lo <= v < hi.
    function automatic logic in_range(coord_t v, int unsigned lo, int unsigned hi);
        return (32'(v) >= lo) && (32'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Divides the system clock into a one-clk pixel-rate strobe every CLK_DIV clocks.
module vga_pixel_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;

    always_comb begin
        div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Gating with reset keeps the strobe low in reset even when CLK_DIV is 1.
    assign p_tick = ~reset & (div_q == DivLast);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, sync and video_on decode, frame strobe.
// Define VGA_SYNC_REGOUT_EN to register hsync, vsync and video_on.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK,
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned HsStart = H_DISPLAY + H_FRONT;
    localparam int unsigned HsEnd   = H_DISPLAY + H_FRONT + H_SYNC;
    localparam int unsigned VsStart = V_DISPLAY + V_FRONT;
    localparam int unsigned VsEnd   = V_DISPLAY + V_FRONT + V_SYNC;

    localparam coord_t HLast = coord_t'(H_TOTAL - 1);
    localparam coord_t VLast = coord_t'(V_TOTAL - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    if (CLK_DIV < 1) begin : g_div_check
        $error("vga_sync_gen: CLK_DIV must be at least 1");
    end

    vga_pixel_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick (
        .clk   (clk),
        .reset (reset),
        .p_tick(p_tick)
    );

    coord_t x_q, x_d, y_q, y_d;
    logic   x_wrap;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        x_wrap = p_tick && (x_q == HLast);
        if (p_tick) begin
            x_d = x_wrap ? '0 : x_q + coord_t'(1);
        end
        if (x_wrap) begin
            y_d = (y_q == VLast) ? '0 : y_q + coord_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = x_wrap && (y_q == VLast);

    // Returns {visible, hsync_n, vsync_n} for a coordinate pair.
    function automatic logic [2:0] sync_decode(coord_t cx, coord_t cy);
        logic vis, hs, vs;
        vis = (32'(cx) < H_DISPLAY) && (32'(cy) < V_DISPLAY);
        hs  = ~in_range(cx, HsStart, HsEnd);
        vs  = ~in_range(cy, VsStart, VsEnd);
        return {vis, hs, vs};
    endfunction

    logic [2:0] sync_raw;

`ifdef VGA_SYNC_REGOUT_EN
    logic [2:0] sync_q;

    // Loading from the next-state counters keeps the flops aligned with x/y.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= sync_decode('0, '0);
        end else begin
            sync_q <= sync_decode(x_d, y_d);
        end
    end

    assign sync_raw = sync_q;
`else
    assign sync_raw = sync_decode(x_q, y_q);
`endif

    // Counters sit at 0,0 in reset, so video_on must be masked explicitly.
    assign video_on = sync_raw[2] & ~reset;
    assign hsync    = sync_raw[1];
    assign vsync    = sync_raw[0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full 640x480 timing plus a reduced-size frame.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total = 0;
    int   bad   = 0;

    // a: defaults; b: defaults with CLK_DIV=1; c: small frame CLK_DIV=3; d: small frame CLK_DIV=1
    logic       p_tick_a, video_a, hsync_a, vsync_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       p_tick_b, video_b, hsync_b, vsync_b, fs_b;
    logic [9:0] x_b, y_b;
    logic       p_tick_c, video_c, hsync_c, vsync_c, fs_c;
    logic [9:0] x_c, y_c;
    logic       p_tick_d, video_d, hsync_d, vsync_d, fs_d;
    logic [9:0] x_d, y_d;

    vga_sync_gen u_dut_a (
        .clk(clk), .reset(rst), .p_tick(p_tick_a), .x(x_a), .y(y_a), .video_on(video_a),
        .hsync(hsync_a), .vsync(vsync_a), .frame_start(fs_a)
    );

    vga_sync_gen #(.CLK_DIV(1)) u_dut_b (
        .clk(clk), .reset(rst), .p_tick(p_tick_b), .x(x_b), .y(y_b), .video_on(video_b),
        .hsync(hsync_b), .vsync(vsync_b), .frame_start(fs_b)
    );

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(3)
    ) u_dut_c (
        .clk(clk), .reset(rst), .p_tick(p_tick_c), .x(x_c), .y(y_c), .video_on(video_c),
        .hsync(hsync_c), .vsync(vsync_c), .frame_start(fs_c)
    );

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(1)
    ) u_dut_d (
        .clk(clk), .reset(rst), .p_tick(p_tick_d), .x(x_d), .y(y_d), .video_on(video_d),
        .hsync(hsync_d), .vsync(vsync_d), .frame_start(fs_d)
    );

    // Leaves the bench at the first negedge after release (counters at 0,0).
    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int fs_seen = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (x_a !== 10'd0) begin bad++; $display("FAIL rst_x: got %0d want 0", x_a); end
        total++; if (y_a !== 10'd0) begin bad++; $display("FAIL rst_y: got %0d want 0", y_a); end
        total++; if (p_tick_a !== 1'b0) begin bad++; $display("FAIL rst_tick: got %b want 0", p_tick_a); end
        total++; if (p_tick_b !== 1'b0) begin bad++; $display("FAIL rst_tick_div1: got %b want 0", p_tick_b); end
        total++; if (fs_a !== 1'b0) begin bad++; $display("FAIL rst_fs: got %b want 0", fs_a); end
        total++; if (hsync_a !== 1'b1) begin bad++; $display("FAIL rst_hsync: got %b want 1", hsync_a); end
        total++; if (vsync_a !== 1'b1) begin bad++; $display("FAIL rst_vsync: got %b want 1", vsync_a); end
        total++; if (video_a !== 1'b0) begin bad++; $display("FAIL rst_video: got %b want 0", video_a); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (video_a !== 1'b1) begin bad++; $display("FAIL rel_video: got %b want 1", video_a); end
        total++; if (hsync_a !== 1'b1 || vsync_a !== 1'b1) begin
            bad++; $display("FAIL rel_sync: got %b%b want 11", hsync_a, vsync_a);
        end
        total++; if (p_tick_a !== 1'b0) begin bad++; $display("FAIL rel_tick: got %b want 0", p_tick_a); end
        total++; if (p_tick_b !== 1'b1) begin bad++; $display("FAIL rel_tick_div1: got %b want 1", p_tick_b); end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (fs_a) fs_seen++;
            total++; if (p_tick_a !== 1'((k % 4) == 3)) begin
                bad++; $display("FAIL tick_k%0d: got %b want %b", k, p_tick_a, (k % 4) == 3);
            end
            total++; if (x_a !== 10'(k / 4)) begin
                bad++; $display("FAIL x_k%0d: got %0d want %0d", k, x_a, k / 4);
            end
            total++; if (x_b !== 10'(k) || p_tick_b !== 1'b1) begin
                bad++; $display("FAIL div1_k%0d: got x=%0d tick=%b want x=%0d tick=1", k, x_b, p_tick_b, k);
            end
        end
        total++; if (fs_seen != 0) begin bad++; $display("FAIL rel_fs: got %0d pulses want 0", fs_seen); end
    endtask

    task automatic test_line();
        int low_cnt = 0, first_low = -1, last_low = -1;
        int wrap_a1 = -1, wrap_a2 = -1, wrap_b1 = -1, wrap_b2 = -1;
        int y_before = -1, y_after = -1, b_idle = 0;
        logic [9:0] px_a = 10'd0, py_a = 10'd0, px_b = 10'd0;
        apply_reset();
        for (int k = 1; k <= 6404; k++) begin
            @(negedge clk);
            if (k < 3200 && p_tick_a && !hsync_a) begin
                low_cnt++;
                if (first_low < 0) first_low = int'(x_a);
                last_low = int'(x_a);
            end
            if (px_a == 10'd799 && x_a == 10'd0) begin
                if (wrap_a1 < 0) begin
                    wrap_a1 = k; y_before = int'(py_a); y_after = int'(y_a);
                end else if (wrap_a2 < 0) wrap_a2 = k;
            end
            if (px_b == 10'd799 && x_b == 10'd0) begin
                if (wrap_b1 < 0) wrap_b1 = k;
                else if (wrap_b2 < 0) wrap_b2 = k;
            end
            if (!p_tick_b) b_idle++;
            px_a = x_a; py_a = y_a; px_b = x_b;
        end
        total++; if (low_cnt != 96) begin bad++; $display("FAIL hs_width: got %0d want 96", low_cnt); end
        total++; if (first_low != 656) begin bad++; $display("FAIL hs_start: got %0d want 656", first_low); end
        total++; if (last_low != 751) begin bad++; $display("FAIL hs_end: got %0d want 751", last_low); end
        total++; if (wrap_a1 != 3200) begin bad++; $display("FAIL xwrap_at: got %0d want 3200", wrap_a1); end
        total++; if (y_before != 0 || y_after != 1) begin
            bad++; $display("FAIL y_step: got %0d->%0d want 0->1", y_before, y_after);
        end
        total++; if (wrap_a2 - wrap_a1 != 3200) begin
            bad++; $display("FAIL line_period: got %0d want 3200", wrap_a2 - wrap_a1);
        end
        total++; if (wrap_b1 != 800 || wrap_b2 - wrap_b1 != 800) begin
            bad++; $display("FAIL div1_line: got %0d/%0d want 800/800", wrap_b1, wrap_b2 - wrap_b1);
        end
        total++; if (b_idle != 0) begin bad++; $display("FAIL div1_tick_gaps: got %0d want 0", b_idle); end
    endtask

    task automatic test_frame();
        int fs_c1 = -1, fs_c2 = -1, fs_c_cnt = 0, fs_d1 = -1, fs_d2 = -1, fs_d_cnt = 0;
        int vs_cnt = 0, vis_cnt = 0, d_idle = 0;
        int vs_x = -1, vs_y = -1;
        logic v_h_edge = 1'bx, v_v_edge = 1'bx, v_last = 1'bx;
        apply_reset();
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (fs_c) begin
                fs_c_cnt++;
                if (fs_c1 < 0) fs_c1 = k; else if (fs_c2 < 0) fs_c2 = k;
            end
            if (fs_d && k <= 400) begin
                fs_d_cnt++;
                if (fs_d1 < 0) fs_d1 = k; else if (fs_d2 < 0) fs_d2 = k;
            end
            if (k <= 400 && !p_tick_d) d_idle++;
            if (k <= 494 && p_tick_c) begin
                if (!vsync_c) begin
                    vs_cnt++;
                    if (vs_x < 0) begin vs_x = int'(x_c); vs_y = int'(y_c); end
                end
                if (video_c) vis_cnt++;
                if (x_c == 10'd8 && y_c == 10'd0) v_h_edge = video_c;
                if (x_c == 10'd0 && y_c == 10'd6) v_v_edge = video_c;
                if (x_c == 10'd7 && y_c == 10'd5) v_last = video_c;
            end
        end
        total++; if (fs_c1 != 494) begin bad++; $display("FAIL fs_first: got %0d want 494", fs_c1); end
        total++; if (fs_c2 - fs_c1 != 495) begin
            bad++; $display("FAIL frame_period: got %0d want 495", fs_c2 - fs_c1);
        end
        total++; if (fs_c_cnt != 2) begin bad++; $display("FAIL fs_width: got %0d clks want 2", fs_c_cnt); end
        total++; if (vs_cnt != 30) begin bad++; $display("FAIL vs_width: got %0d want 30", vs_cnt); end
        total++; if (vs_x != 0 || vs_y != 7) begin
            bad++; $display("FAIL vs_start: got (%0d,%0d) want (0,7)", vs_x, vs_y);
        end
        total++; if (vis_cnt != 48) begin bad++; $display("FAIL visible: got %0d want 48", vis_cnt); end
        total++; if (v_h_edge !== 1'b0) begin bad++; $display("FAIL vid_hdisp: got %b want 0", v_h_edge); end
        total++; if (v_v_edge !== 1'b0) begin bad++; $display("FAIL vid_vdisp: got %b want 0", v_v_edge); end
        total++; if (v_last !== 1'b1) begin bad++; $display("FAIL vid_last: got %b want 1", v_last); end
        total++; if (fs_d1 != 164 || fs_d2 - fs_d1 != 165 || fs_d_cnt != 2) begin
            bad++; $display("FAIL div1_frame: got %0d/%0d/%0d want 164/165/2", fs_d1, fs_d2 - fs_d1, fs_d_cnt);
        end
        total++; if (d_idle != 0) begin bad++; $display("FAIL div1_small_tick: got %0d want 0", d_idle); end
    endtask

    task automatic test_mid_reset();
        int n = 0, fs_seen = 0;
        apply_reset();
        while (!(x_a == 10'd300 && y_a == 10'd1) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        total++; if (x_a !== 10'd300 || y_a !== 10'd1) begin
            bad++; $display("FAIL mid_reach: got (%0d,%0d) want (300,1)", x_a, y_a);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (x_a !== 10'd0 || y_a !== 10'd0) begin
            bad++; $display("FAIL mid_xy: got (%0d,%0d) want (0,0)", x_a, y_a);
        end
        total++; if (p_tick_a !== 1'b0 || fs_a !== 1'b0) begin
            bad++; $display("FAIL mid_strobes: got tick=%b fs=%b want 0 0", p_tick_a, fs_a);
        end
        total++; if (x_c !== 10'd0 || y_c !== 10'd0) begin
            bad++; $display("FAIL mid_small_xy: got (%0d,%0d) want (0,0)", x_c, y_c);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (fs_a) fs_seen++;
            total++; if (p_tick_a !== 1'((k % 4) == 3) || x_a !== 10'(k / 4)) begin
                bad++; $display("FAIL mid_k%0d: got tick=%b x=%0d want tick=%b x=%0d",
                                k, p_tick_a, x_a, (k % 4) == 3, k / 4);
            end
        end
        total++; if (fs_seen != 0) begin bad++; $display("FAIL mid_fs: got %0d want 0", fs_seen); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_line();
        test_frame();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
